// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_OVERSAMPLE = 16;

    localparam logic [1:0] UART_ST_IDLE  = 2'd0;
    localparam logic [1:0] UART_ST_START = 2'd1;
    localparam logic [1:0] UART_ST_DATA  = 2'd2;
    localparam logic [1:0] UART_ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = UART_ST_IDLE,
        ST_START = UART_ST_START,
        ST_DATA  = UART_ST_DATA,
        ST_STOP  = UART_ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sfifo.sv
// Show-ahead synchronous FIFO: register array, registered write, combinational head read.
module uart_rx_sfifo #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(2 ** FIFO_AW);

    logic [DATA_W-1:0]  mem [2 ** FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               do_wr;
    logic               do_rd;

    // Full/empty come from the pre-pop count, so a same-cycle pop never frees a slot for a write.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;
    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchroniser, oversampling FSM, shift register and receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int FIFO_AW    = 4
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       clk_uart,
    input  logic       RXD,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       empty,
    output logic       state,
    output logic       frame_err,
    output logic       overrun,
    output logic       bps_en
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

    logic                      rx_s1;
    logic                      rxs;
    logic                      rxs_prev;
    uart_state_e               st;
    logic [CW-1:0]             tick_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      fifo_full;
    logic                      fifo_wr;
    logic                      bit_tick;
    logic                      stop_tick;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rx_s1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_s1    <= RXD;
            rxs      <= rx_s1;
            rxs_prev <= rxs;
        end
    end

    assign bit_tick  = clk_uart && (tick_cnt == FULL_LAST);
    assign stop_tick = (st == ST_STOP) && bit_tick;
    assign fifo_wr   = stop_tick && rxs && !fifo_full;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            st        <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            bps_en    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (st)
                ST_IDLE: begin
                    // Edge-triggered start: a line stuck low after a break cannot retrigger.
                    if (!rxs && rxs_prev) begin
                        st       <= ST_START;
                        bps_en   <= 1'b1;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_START: begin
                    if (clk_uart) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            if (rxs) begin
                                st     <= ST_IDLE;
                                bps_en <= 1'b0;
                            end else begin
                                st <= ST_DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        tick_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST)
                            st <= ST_STOP;
                    end else if (clk_uart) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (stop_tick) begin
                        st       <= ST_IDLE;
                        bps_en   <= 1'b0;
                        tick_cnt <= '0;
                        if (!rxs)
                            frame_err <= 1'b1;
                        else if (fifo_full)
                            overrun <= 1'b1;
                    end else if (clk_uart) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    st     <= ST_IDLE;
                    bps_en <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((st == ST_DATA) && bit_tick)
            shreg <= {rxs, shreg[UART_DATA_BITS-1:1]};
    end

    uart_rx_sfifo #(
        .DATA_W  (UART_DATA_BITS),
        .FIFO_AW (FIFO_AW)
    ) u_sfifo (
        .clk   (clk),
        .RST   (RST),
        .wr_en (fifo_wr),
        .rd_en (rd_en),
        .din   (shreg),
        .dout  (data),
        .empty (empty),
        .full  (fifo_full)
    );

    assign state = fifo_full;

endmodule
